// File: rtl/mux_ser_pkg.sv
// Shared types and widths for the mux_serializer8 slice.
// The MUX_SER_PARITY_EN build option is handled in the top level. This
// package always declares the PARITY state so that both builds share one type.
package mux_ser_pkg;

    localparam int MUX_SER_DATA_W = 8;
    localparam int MUX_SER_SEL_W  = 3;
    localparam int MUX_SER_GAP_W  = 8;

    // One state per kind of output cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } mux_ser_state_t;

endpackage

// File: rtl/mux8to1.sv
// Plain 8:1 bit-select mux: y = d[sel].
module mux8to1
    import mux_ser_pkg::*;
(
    input  logic [MUX_SER_DATA_W-1:0] d,
    input  logic [MUX_SER_SEL_W-1:0]  sel,
    output logic                      y
);

    // Pick one bit of the word.
    always_comb begin
        y = 1'b0;
        case (sel)
            3'd0: y = d[0];
            3'd1: y = d[1];
            3'd2: y = d[2];
            3'd3: y = d[3];
            3'd4: y = d[4];
            3'd5: y = d[5];
            3'd6: y = d[6];
            3'd7: y = d[7];
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_serializer8.sv
// 8-bit parallel-to-serial front end. A word is accepted over valid/ready.
// It is then streamed LSB first, one bit per cycle, with valid and last markers.
// Build option: define MUX_SER_PARITY_EN to append an even-parity bit.
// That bit becomes the frame's last bit, so a frame is 9 cycles long.
// IDLE_GAP inserts idle cycles after each frame. When IDLE_GAP is nonzero,
// back-to-back acceptance is turned off.
module mux_serializer8
    import mux_ser_pkg::*;
#(
    parameter int IDLE_GAP = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MUX_SER_DATA_W-1:0] d,
    input  logic                      d_valid,
    output logic                      d_ready,
    output logic                      y,
    output logic                      y_valid,
    output logic                      y_last,
    output logic [MUX_SER_SEL_W-1:0]  s
);

    localparam logic HAS_GAP = (IDLE_GAP > 0);
    localparam logic [MUX_SER_GAP_W-1:0] GAP_LAST =
        (IDLE_GAP > 0) ? MUX_SER_GAP_W'(IDLE_GAP - 1) : '0;
    localparam mux_ser_state_t AFTER_FRAME = HAS_GAP ? GAP : IDLE;

    mux_ser_state_t              state, state_n;
    logic [MUX_SER_DATA_W-1:0]   hold, hold_n;
    logic [MUX_SER_SEL_W-1:0]    s_n, sel_nxt;
    logic [MUX_SER_GAP_W-1:0]    gap_cnt, gap_cnt_n;
    logic                        y_n, y_valid_n, y_last_n;
    logic                        mux_bit;
    logic                        final_bit;
    logic                        accept;

    // The select for the next bit. The wrap from 7 to 0 is never used,
    // because a frame's start always loads s directly.
    assign sel_nxt = s + 3'd1;

    mux8to1 u_mux (
        .d   (hold),
        .sel (sel_nxt),
        .y   (mux_bit)
    );

    // Marks the cycle that shows the frame's last bit. In that cycle the
    // next word may be accepted so that frames run back to back.
`ifdef MUX_SER_PARITY_EN
    assign final_bit = (state == PARITY);
`else
    assign final_bit = (state == SHIFT) && (s == 3'd7);
`endif

    assign d_ready = !rst && ((state == IDLE) || (final_bit && !HAS_GAP));
    assign accept  = d_valid && d_ready;

    // Next state and next registered outputs. Accepting a word overrides
    // everything else.
    always_comb begin
        state_n   = state;
        hold_n    = hold;
        s_n       = s;
        gap_cnt_n = gap_cnt;
        y_n       = 1'b0;
        y_valid_n = 1'b0;
        y_last_n  = 1'b0;

        case (state)
            IDLE: begin
                state_n = IDLE;
            end
            SHIFT: begin
                if (s != 3'd7) begin
                    s_n       = sel_nxt;
                    y_n       = mux_bit;
                    y_valid_n = 1'b1;
`ifndef MUX_SER_PARITY_EN
                    y_last_n  = (sel_nxt == 3'd7);
`endif
                end else begin
`ifdef MUX_SER_PARITY_EN
                    // s stays at 7 during the parity cycle.
                    state_n   = PARITY;
                    y_n       = ^hold;
                    y_valid_n = 1'b1;
                    y_last_n  = 1'b1;
`else
                    state_n   = AFTER_FRAME;
                    gap_cnt_n = '0;
`endif
                end
            end
`ifdef MUX_SER_PARITY_EN
            PARITY: begin
                state_n   = AFTER_FRAME;
                gap_cnt_n = '0;
            end
`endif
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n   = IDLE;
                    gap_cnt_n = '0;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (accept) begin
            state_n   = SHIFT;
            hold_n    = d;
            s_n       = '0;
            y_n       = d[0];
            y_valid_n = 1'b1;
            y_last_n  = 1'b0;
        end
    end

    // State and output registers. Reset is synchronous, so a reset during
    // a frame throws the frame away.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hold    <= '0;
            s       <= '0;
            gap_cnt <= '0;
            y       <= 1'b0;
            y_valid <= 1'b0;
            y_last  <= 1'b0;
        end else begin
            state   <= state_n;
            hold    <= hold_n;
            s       <= s_n;
            gap_cnt <= gap_cnt_n;
            y       <= y_n;
            y_valid <= y_valid_n;
            y_last  <= y_last_n;
        end
    end

endmodule

// File: tb/tb_mux_serializer8.sv
// Self-checking bench for mux_serializer8. The bench uses two instances,
// with IDLE_GAP = 0 and IDLE_GAP = 3.
// Expected bits go into a scoreboard queue when a word is accepted.
// They are popped and compared when the design shows them.
module tb_mux_serializer8;

`ifdef MUX_SER_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d   = 8'h00;
    logic       dv0 = 1'b0;
    logic       dv3 = 1'b0;
    logic       dr0, y0, yv0, yl0;
    logic       dr3, y3, yv3, yl3;
    logic [2:0] s0, s3;

    always #5 clk = ~clk;

    mux_serializer8 #(.IDLE_GAP(0)) u0 (
        .clk(clk), .rst(rst), .d(d), .d_valid(dv0), .d_ready(dr0),
        .y(y0), .y_valid(yv0), .y_last(yl0), .s(s0)
    );

    mux_serializer8 #(.IDLE_GAP(3)) u3 (
        .clk(clk), .rst(rst), .d(d), .d_valid(dv3), .d_ready(dr3),
        .y(y3), .y_valid(yv3), .y_last(yl3), .s(s3)
    );

    typedef struct packed {
        logic       y;
        logic [2:0] s;
        logic       last;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Expected stream for one accepted word.
    function automatic void push_frame(input logic [7:0] w);
        for (int k = 0; k < 8; k++)
            sbq.push_back({w[k], 3'(k), (FLEN == 8) && (k == 7)});
        if (FLEN == 9)
            sbq.push_back({^w, 3'd7, 1'b1});
    endfunction

    task automatic test_reset();
        rst = 1'b1; dv0 = 1'b0; dv3 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++;
            if ({y0, yv0, yl0, s0, dr0, y3, yv3, yl3, s3, dr3} !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_state cyc%0d: got %b, want all zero", i,
                         {y0, yv0, yl0, s0, dr0, y3, yv3, yl3, s3, dr3});
            end
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if ({dr0, dr3} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, want 11", {dr0, dr3});
        end
        sbq.delete();
    endtask

    task automatic test_single();
        exp_t       e;
        logic [7:0] yseq = 8'h00;
        @(negedge clk);
        d = 8'hA5; dv0 = 1'b1;
        #1;
        n_chk++;
        if (dr0 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b, want 1", dr0);
        end
        if (dv0 && dr0) push_frame(d);
        for (int c = 1; c <= FLEN + 1; c++) begin
            @(negedge clk);
            dv0 = 1'b0;
            if (c <= 8) yseq[c-1] = y0;
            n_chk++;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if ({yv0, y0, s0, yl0} !== {1'b1, e}) begin
                    n_fail++;
                    $display("FAIL single_bit c%0d: got v%b y%b s%0d l%b, want v1 y%b s%0d l%b",
                             c, yv0, y0, s0, yl0, e.y, e.s, e.last);
                end
            end else if ({yv0, y0, yl0} !== 3'b000) begin
                n_fail++;
                $display("FAIL single_end c%0d: got v%b y%b l%b, want 000", c, yv0, y0, yl0);
            end
        end
        n_chk++;
        if (yseq !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_sequence: got %h, want a5", yseq);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [2] = '{8'h01, 8'h80};
        exp_t e;
        int   wi = 0, run = 0, maxrun = 0;
        for (int c = 0; c < 2 * FLEN + 3; c++) begin
            @(negedge clk);
            n_chk++;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if ({yv0, y0, s0, yl0} !== {1'b1, e}) begin
                    n_fail++;
                    $display("FAIL b2b_bit c%0d: got v%b y%b s%0d l%b, want v1 y%b s%0d l%b",
                             c, yv0, y0, s0, yl0, e.y, e.s, e.last);
                end
            end else if (yv0 !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle_valid c%0d: got %b, want 0", c, yv0);
            end
            n_chk++;
            if (dr0 !== (sbq.size() == 0)) begin
                n_fail++;
                $display("FAIL b2b_ready c%0d: got %b, want %b", c, dr0, sbq.size() == 0);
            end
            run    = yv0 ? run + 1 : 0;
            maxrun = (run > maxrun) ? run : maxrun;
            if (wi < 2) begin d = words[wi]; dv0 = 1'b1; end
            else        dv0 = 1'b0;
            #1;
            if (dv0 && dr0) begin push_frame(d); wi++; end
        end
        dv0 = 1'b0;
        n_chk++;
        if (maxrun != 2 * FLEN || wi != 2) begin
            n_fail++;
            $display("FAIL b2b_contiguous: got run %0d words %0d, want run %0d words 2",
                     maxrun, wi, 2 * FLEN);
        end
    endtask

    task automatic test_patterns();
        logic [7:0] words [6] = '{8'h07, 8'h03, 8'hFF, 8'h00, 8'h5A, 8'hC3};
        exp_t e;
        int   wi = 0;
        bit   pend = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_chk++;
                if ({yv0, y0, s0, yl0} !== {1'b1, e}) begin
                    n_fail++;
                    $display("FAIL pat_bit c%0d: got v%b y%b s%0d l%b, want v1 y%b s%0d l%b",
                             c, yv0, y0, s0, yl0, e.y, e.s, e.last);
                end
            end else if (yv0 !== 1'b0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pat_idle_valid c%0d: got %b, want 0", c, yv0);
            end
            n_chk++;
            if (dr0 !== (sbq.size() == 0)) begin
                n_fail++;
                $display("FAIL pat_ready c%0d: got %b, want %b", c, dr0, sbq.size() == 0);
            end
            if (wi == 6 && sbq.size() == 0 && !pend) break;
            if (!pend && wi < 6 && $urandom_range(0, 2) != 0) begin
                d = words[wi]; dv0 = 1'b1; pend = 1'b1;
            end else if (!pend) begin
                d = 8'($urandom); dv0 = 1'b0;
            end
            #1;
            if (dv0 && dr0) begin push_frame(d); wi++; pend = 1'b0; end
        end
        dv0 = 1'b0;
        n_chk++;
        if (wi != 6 || sbq.size() != 0) begin
            n_fail++;
            $display("FAIL pat_timeout: got %0d words, %0d pending bits, want 6 and 0", wi, sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_gap();
        logic [7:0] words [2] = '{8'hC3, 8'h3C};
        exp_t e;
        int   wi = 0, npop = 0, t_last = -1, t_b0 = -1, nz = 0;
        bit   seen_ready = 1'b0;
        for (int c = 0; c < 2 * FLEN + 12; c++) begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_chk++;
                if ({yv3, y3, s3, yl3} !== {1'b1, e}) begin
                    n_fail++;
                    $display("FAIL gap_bit c%0d: got v%b y%b s%0d l%b, want v1 y%b s%0d l%b",
                             c, yv3, y3, s3, yl3, e.y, e.s, e.last);
                end
                if (npop == FLEN - 1) t_last = c;
                if (npop == FLEN)     t_b0   = c;
                npop++;
            end else if ({yv3, y3} !== 2'b00) begin
                n_chk++;
                n_fail++;
                $display("FAIL gap_idle c%0d: got v%b y%b, want 00", c, yv3, y3);
            end
            if (t_last >= 0 && !seen_ready) begin
                if (dr3) seen_ready = 1'b1;
                else     nz++;
            end
            if (wi < 2) begin d = words[wi]; dv3 = 1'b1; end
            else        dv3 = 1'b0;
            #1;
            if (dv3 && dr3) begin push_frame(d); wi++; end
        end
        dv3 = 1'b0;
        n_chk++;
        if (nz != 4) begin
            n_fail++;
            $display("FAIL gap_ready_low: got %0d cycles, want 4", nz);
        end
        n_chk++;
        if (t_last < 0 || t_b0 - t_last != 5) begin
            n_fail++;
            $display("FAIL gap_spacing: got %0d, want 5", t_b0 - t_last);
        end
        n_chk++;
        if (sbq.size() != 0 || wi != 2) begin
            n_fail++;
            $display("FAIL gap_drain: got %0d pending, %0d words, want 0 and 2", sbq.size(), wi);
        end
        sbq.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   hit = 1'b0;
        @(negedge clk);
        d = 8'hFF; dv0 = 1'b1;
        #1;
        if (dv0 && dr0) push_frame(d);
        for (int c = 1; c <= FLEN; c++) begin
            @(negedge clk);
            dv0 = 1'b0;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_chk++;
                if ({yv0, y0, s0, yl0} !== {1'b1, e}) begin
                    n_fail++;
                    $display("FAIL rstmid_bit c%0d: got v%b y%b s%0d l%b, want v1 y%b s%0d l%b",
                             c, yv0, y0, s0, yl0, e.y, e.s, e.last);
                end
                if (e.s == 3'd4) begin hit = 1'b1; rst = 1'b1; break; end
            end
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL rstmid_no_bit4: got none, want bit 4");
        end
        sbq.delete();
        @(negedge clk);
        n_chk++;
        if ({yv0, yl0, s0, dr0} !== 6'b0) begin
            n_fail++;
            $display("FAIL rstmid_abort: got v%b l%b s%0d r%b, want all 0", yv0, yl0, s0, dr0);
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if (dr0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_ready: got %b, want 1", dr0);
        end
        @(negedge clk);
        n_chk++;
        if ({yv0, yl0} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_after: got v%b l%b, want 00", yv0, yl0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_patterns();
        test_gap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
